// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the MIPS pipeline hazard controller.
// The stall-cause bit positions are also used by the testbench.
package hazard_pkg;

  typedef enum logic {
    RUN     = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

  localparam int CAUSE_LW = 0;
  localparam int CAUSE_BR = 1;
  localparam int CAUSE_MD = 2;
  localparam int CAUSE_W  = 3;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-controller bundle: pipeline status in, stall/flush controls out.
// The master is the pipeline datapath; the slave is the hazard controller.
interface pipeline_hazard_ctrl_if;
  import hazard_pkg::*;

  logic [4:0] rsD;
  logic [4:0] rtD;
  logic [4:0] rtE;
  logic [4:0] writeRegE;
  logic [4:0] writeRegM;
  logic       RegWriteE;
  logic       MemtoRegE;
  logic       MemtoRegM;
  logic       BranchD;
  logic       JumpD;
  logic       PCSrcD;
  logic       MDStartE;
  logic       MDUseD;
  logic       nEN_PC;
  logic       nEN_FD;
  logic       flushFD;
  logic       flushDE;
  logic       mdBusy;

  modport master (
    output rsD, rtD, rtE, writeRegE, writeRegM,
    output RegWriteE, MemtoRegE, MemtoRegM,
    output BranchD, JumpD, PCSrcD, MDStartE, MDUseD,
    input  nEN_PC, nEN_FD, flushFD, flushDE, mdBusy
  );

  modport slave (
    input  rsD, rtD, rtE, writeRegE, writeRegM,
    input  RegWriteE, MemtoRegE, MemtoRegM,
    input  BranchD, JumpD, PCSrcD, MDStartE, MDUseD,
    output nEN_PC, nEN_FD, flushFD, flushDE, mdBusy
  );

endinterface

// File: rtl/pipeline_hazard_ctrl_md_busy_timer.sv
// Tracks occupancy of the multi-cycle mult/div unit: RUN/MD_BUSY FSM
// with a down-counter; mdBusy stays high for MD_LATENCY cycles after issue.
module md_busy_timer
  import hazard_pkg::*;
#(
  parameter int MD_LATENCY = 32
) (
  input  logic CLK,
  input  logic reset,
  input  logic MDStartE,
  output logic mdBusy
);

  localparam int             CW       = $clog2(MD_LATENCY);
  localparam logic [CW-1:0]  CNT_LOAD = CW'(MD_LATENCY - 1);

  md_state_e     state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;

  always_ff @(posedge CLK) begin
    if (!reset) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // A start seen while already busy is dropped: the issuer is stalled anyway.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      RUN: begin
        if (MDStartE) begin
          state_nxt = MD_BUSY;
          cnt_nxt   = CNT_LOAD;
        end
      end
      MD_BUSY: begin
        if (cnt == '0) state_nxt = RUN;
        else           cnt_nxt   = cnt - CW'(1);
      end
      default: state_nxt = RUN;
    endcase
  end

  always_comb begin
    mdBusy = (state == MD_BUSY);
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/stall controller for the 5-stage MIPS pipeline (load-use, branch
// operand and mult/div hazards). HAZARD_PERF_CNT_EN adds a saturating stall counter.
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MD_LATENCY = 32,
  parameter int CNT_W      = 32
) (
  input  logic                  CLK,
  input  logic                  reset,
  pipeline_hazard_ctrl_if.slave hz
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]      stallCount
`endif
);

  logic               md_busy;
  logic [CAUSE_W-1:0] cause;
  logic               stall;

  md_busy_timer #(
    .MD_LATENCY (MD_LATENCY)
  ) u_md_busy_timer (
    .CLK      (CLK),
    .reset    (reset),
    .MDStartE (hz.MDStartE),
    .mdBusy   (md_busy)
  );

  // Register 0 is hard-wired, so a write to it never creates a dependency.
  function automatic logic src_hit(input logic [4:0] dst,
                                   input logic [4:0] srca,
                                   input logic [4:0] srcb);
    return (dst != REG_ZERO) && ((dst == srca) || (dst == srcb));
  endfunction

  always_comb begin
    cause           = '0;
    cause[CAUSE_LW] = hz.MemtoRegE && src_hit(hz.rtE, hz.rsD, hz.rtD);
    cause[CAUSE_BR] = hz.BranchD &&
                      ((hz.RegWriteE && src_hit(hz.writeRegE, hz.rsD, hz.rtD)) ||
                       (hz.MemtoRegM && src_hit(hz.writeRegM, hz.rsD, hz.rtD)));
    cause[CAUSE_MD] = md_busy && hz.MDUseD;
  end

  // Everything is held low while reset is asserted.
  assign stall      = reset && (|cause);
  assign hz.nEN_PC  = stall;
  assign hz.nEN_FD  = stall;
  assign hz.flushDE = stall;
  assign hz.flushFD = reset && (hz.PCSrcD || hz.JumpD) && !stall;
  assign hz.mdBusy  = reset && md_busy;

`ifdef HAZARD_PERF_CNT_EN
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_ff @(posedge CLK) begin
    if (!reset)     stallCount <= '0;
    else if (stall) stallCount <= sat_inc(stallCount);
  end
`else
  logic unused_cnt_w;
  assign unused_cnt_w = ^CNT_W;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl (MD_LATENCY=4, CNT_W=3).
// Expected per-cycle outputs are queued as stimulus is driven and checked at negedge.
module tb_pipeline_hazard_ctrl;
  import hazard_pkg::*;

  localparam int MD_LAT = 4;
  localparam logic [2:0] C_NONE = 3'b000;
  localparam logic [2:0] C_LW   = 3'(1 << CAUSE_LW);
  localparam logic [2:0] C_BR   = 3'(1 << CAUSE_BR);
  localparam logic [2:0] C_MD   = 3'(1 << CAUSE_MD);

  typedef struct {
    string      name;
    logic [2:0] cause;
    logic       flfd;
    logic       busy;
  } exp_t;

  logic CLK = 1'b0;
  logic reset = 1'b0;
  int   n_cmp = 0;
  int   n_fail = 0;
  exp_t sb[$];
  exp_t e;
  logic [4:0] got;

  pipeline_hazard_ctrl_if ifc();

`ifdef HAZARD_PERF_CNT_EN
  logic [2:0] stallCount;
  int         cq[$];
`endif

  pipeline_hazard_ctrl #(
    .MD_LATENCY (MD_LAT),
    .CNT_W      (3)
  ) dut (
    .CLK        (CLK),
    .reset      (reset),
    .hz         (ifc.slave)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .stallCount (stallCount)
`endif
  );

  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required $finish");
    $fatal(1);
  end

  // Issuing a mult/div while the unit is busy is a pipeline protocol error.
  always @(negedge CLK) begin
    if (reset && ifc.MDStartE && ifc.mdBusy) begin
      n_fail++;
      $display("FAIL md_reissue: got MDStartE=1 while mdBusy=1, required no issue while busy");
    end
  end

  // Expected output vector {nEN_PC, nEN_FD, flushFD, flushDE, mdBusy}.
  function automatic logic [4:0] exp_vec(input exp_t x);
    logic s;
    s = |x.cause;
    return {s, s, x.flfd & ~s, s, x.busy};
  endfunction

  function automatic logic [4:0] outs();
    return {ifc.nEN_PC, ifc.nEN_FD, ifc.flushFD, ifc.flushDE, ifc.mdBusy};
  endfunction

  task automatic idle();
    ifc.rsD = 5'd0; ifc.rtD = 5'd0; ifc.rtE = 5'd0;
    ifc.writeRegE = 5'd0; ifc.writeRegM = 5'd0;
    ifc.RegWriteE = 1'b0; ifc.MemtoRegE = 1'b0; ifc.MemtoRegM = 1'b0;
    ifc.BranchD = 1'b0; ifc.JumpD = 1'b0; ifc.PCSrcD = 1'b0;
    ifc.MDStartE = 1'b0; ifc.MDUseD = 1'b0;
  endtask

  task automatic push(input string n, input logic [2:0] c, input logic f, input logic b);
    exp_t x;
    x.name = n; x.cause = c; x.flfd = f; x.busy = b;
    sb.push_back(x);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK); #1; idle();
      case (i)
        0, 1: begin
          reset = 1'b0;
          ifc.MemtoRegE = 1'b1; ifc.rtE = 5'd8; ifc.rsD = 5'd8;
          ifc.PCSrcD = 1'b1; ifc.MDStartE = 1'b1;
          push("reset_held", C_NONE, 1'b0, 1'b0);
        end
        default: begin
          reset = 1'b1;
          push("reset_release", C_NONE, 1'b0, 1'b0);
        end
      endcase
      @(negedge CLK);
      e = sb.pop_front(); got = outs(); n_cmp++;
      if (got !== exp_vec(e)) begin
        n_fail++;
        $display("FAIL %s: got %b required %b", e.name, got, exp_vec(e));
      end
    end
  endtask

  task automatic test_load_use();
    for (int i = 0; i < 4; i++) begin
      @(posedge CLK); #1; idle();
      case (i)
        0: begin ifc.MemtoRegE = 1'b1; ifc.rtE = 5'd8; ifc.rsD = 5'd8;
                 push("lw_rs", C_LW, 1'b0, 1'b0); end
        1: push("lw_bubble", C_NONE, 1'b0, 1'b0);
        2: begin ifc.MemtoRegE = 1'b1; ifc.rtE = 5'd0; ifc.rsD = 5'd0; ifc.rtD = 5'd0;
                 push("lw_r0", C_NONE, 1'b0, 1'b0); end
        default: begin ifc.MemtoRegE = 1'b1; ifc.rtE = 5'd12; ifc.rtD = 5'd12; ifc.rsD = 5'd3;
                 push("lw_rt", C_LW, 1'b0, 1'b0); end
      endcase
      @(negedge CLK);
      e = sb.pop_front(); got = outs(); n_cmp++;
      if (got !== exp_vec(e)) begin
        n_fail++;
        $display("FAIL %s: got %b required %b", e.name, got, exp_vec(e));
      end
    end
  endtask

  task automatic test_branch();
    for (int i = 0; i < 6; i++) begin
      @(posedge CLK); #1; idle();
      ifc.BranchD = 1'b1;
      case (i)
        0: begin ifc.RegWriteE = 1'b1; ifc.writeRegE = 5'd9; ifc.rtD = 5'd9; ifc.rsD = 5'd2;
                 push("br_alu_e", C_BR, 1'b0, 1'b0); end
        1: begin ifc.writeRegM = 5'd9; ifc.rtD = 5'd9; ifc.rsD = 5'd2;
                 push("br_alu_m", C_NONE, 1'b0, 1'b0); end
        2: begin ifc.RegWriteE = 1'b1; ifc.MemtoRegE = 1'b1; ifc.writeRegE = 5'd9;
                 ifc.rtE = 5'd9; ifc.rsD = 5'd9;
                 push("br_load_e", C_LW | C_BR, 1'b0, 1'b0); end
        3: begin ifc.MemtoRegM = 1'b1; ifc.writeRegM = 5'd9; ifc.rsD = 5'd9;
                 push("br_load_m", C_BR, 1'b0, 1'b0); end
        4: begin ifc.rsD = 5'd9; ifc.PCSrcD = 1'b1;
                 push("br_resolved", C_NONE, 1'b1, 1'b0); end
        default: begin ifc.RegWriteE = 1'b1; ifc.writeRegE = 5'd0;
                 ifc.MemtoRegM = 1'b1; ifc.writeRegM = 5'd0;
                 push("br_r0", C_NONE, 1'b0, 1'b0); end
      endcase
      @(negedge CLK);
      e = sb.pop_front(); got = outs(); n_cmp++;
      if (got !== exp_vec(e)) begin
        n_fail++;
        $display("FAIL %s: got %b required %b", e.name, got, exp_vec(e));
      end
    end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 4; i++) begin
      @(posedge CLK); #1; idle();
      case (i)
        0: begin ifc.PCSrcD = 1'b1; push("taken_branch", C_NONE, 1'b1, 1'b0); end
        1: begin ifc.JumpD = 1'b1;  push("jump", C_NONE, 1'b1, 1'b0); end
        2: begin ifc.PCSrcD = 1'b1; ifc.MemtoRegE = 1'b1; ifc.rtE = 5'd4; ifc.rsD = 5'd4;
                 push("taken_vs_lw", C_LW, 1'b1, 1'b0); end
        default: begin ifc.PCSrcD = 1'b1; ifc.BranchD = 1'b1; ifc.RegWriteE = 1'b1;
                 ifc.writeRegE = 5'd5; ifc.rsD = 5'd6; ifc.rtD = 5'd7;
                 push("taken_no_hazard", C_NONE, 1'b1, 1'b0); end
      endcase
      @(negedge CLK);
      e = sb.pop_front(); got = outs(); n_cmp++;
      if (got !== exp_vec(e)) begin
        n_fail++;
        $display("FAIL %s: got %b required %b", e.name, got, exp_vec(e));
      end
    end
  endtask

  task automatic test_muldiv();
    for (int i = 0; i < 7; i++) begin
      @(posedge CLK); #1; idle();
      case (i)
        0: begin ifc.MDStartE = 1'b1; push("md_issue", C_NONE, 1'b0, 1'b0); end
        1: begin ifc.PCSrcD = 1'b1; push("md_busy_flush", C_NONE, 1'b1, 1'b1); end
        2, 3, 4: begin ifc.MDUseD = 1'b1; push("md_use_stall", C_MD, 1'b0, 1'b1); end
        5: begin ifc.MDUseD = 1'b1; push("md_release", C_NONE, 1'b0, 1'b0); end
        default: push("md_idle", C_NONE, 1'b0, 1'b0);
      endcase
      @(negedge CLK);
      e = sb.pop_front(); got = outs(); n_cmp++;
      if (got !== exp_vec(e)) begin
        n_fail++;
        $display("FAIL %s[%0d]: got %b required %b", e.name, i, got, exp_vec(e));
      end
    end
  endtask

  task automatic test_reset_mid_busy();
    for (int i = 0; i < 11; i++) begin
      @(posedge CLK); #1; idle();
      reset = 1'b1;
      case (i)
        0: begin ifc.MDStartE = 1'b1; push("mr_issue", C_NONE, 1'b0, 1'b0); end
        1: push("mr_busy", C_NONE, 1'b0, 1'b1);
        2, 3: begin reset = 1'b0; ifc.MDUseD = 1'b1; ifc.PCSrcD = 1'b1;
                    push("mr_held", C_NONE, 1'b0, 1'b0); end
        4: begin ifc.MDUseD = 1'b1; push("mr_run_after", C_NONE, 1'b0, 1'b0); end
        5: begin ifc.MDStartE = 1'b1; push("mr_reissue", C_NONE, 1'b0, 1'b0); end
        6: begin ifc.MDUseD = 1'b1; push("mr_use", C_MD, 1'b0, 1'b1); end
        7, 8, 9: push("mr_drain", C_NONE, 1'b0, 1'b1);
        default: push("mr_done", C_NONE, 1'b0, 1'b0);
      endcase
      @(negedge CLK);
      e = sb.pop_front(); got = outs(); n_cmp++;
      if (got !== exp_vec(e)) begin
        n_fail++;
        $display("FAIL %s[%0d]: got %b required %b", e.name, i, got, exp_vec(e));
      end
    end
  endtask

`ifdef HAZARD_PERF_CNT_EN
  task automatic test_perf_cnt();
    int exp_cnt;
    for (int i = 0; i < 13; i++) begin
      @(posedge CLK); #1; idle();
      reset = !(i == 0 || i == 11);
      if (i >= 1 && i <= 9) begin
        ifc.MemtoRegE = 1'b1; ifc.rtE = 5'd3; ifc.rsD = 5'd3;
        if (i == 5) begin ifc.BranchD = 1'b1; ifc.RegWriteE = 1'b1; ifc.writeRegE = 5'd3; end
      end
      if (i == 12) begin ifc.MemtoRegE = 1'b1; ifc.rtE = 5'd3; ifc.rsD = 5'd3; reset = 1'b0; end
      @(negedge CLK);
      if (cq.size() != 0) begin
        exp_cnt = cq.pop_front(); n_cmp++;
        if (stallCount !== 3'(exp_cnt)) begin
          n_fail++;
          $display("FAIL stall_count[%0d]: got %0d required %0d", i, stallCount, exp_cnt);
        end
      end
      // Count visible in the next cycle: 0 after reset, saturating at 7.
      if (i == 0 || i == 11) cq.push_back(0);
      else if (i <= 9)       cq.push_back((i < 7) ? i : 7);
      else if (i == 10)      cq.push_back(7);
    end
  endtask
`endif

  initial begin
    idle();
    test_reset();
    test_load_use();
    test_branch();
    test_flush();
    test_muldiv();
    test_reset_mid_busy();
`ifdef HAZARD_PERF_CNT_EN
    test_perf_cnt();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
